// File: rtl/uart_rx_int_ctrl_pkg.sv
// rtl/uart_rx_int_ctrl_pkg.sv - shared IID codes, trigger encodings and FIFO counter width
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

package uart_rx_int_ctrl_pkg;

  // 16550-style interrupt identification codes
  localparam logic [3:0] UART_II_RLS  = 4'b0110;
  localparam logic [3:0] UART_II_RDA  = 4'b0100;
  localparam logic [3:0] UART_II_TI   = 4'b1100;
  localparam logic [3:0] UART_II_NONE = 4'b0001;

  // FCR[7:6] trigger-level encodings
  localparam logic [1:0] UART_FC_1  = 2'b00;
  localparam logic [1:0] UART_FC_4  = 2'b01;
  localparam logic [1:0] UART_FC_8  = 2'b10;
  localparam logic [1:0] UART_FC_14 = 2'b11;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_POP  = 2'd1,
    PS_HOLD = 2'd2
  } pop_state_e;

  // Byte count at which the received-data interrupt fires
  function automatic logic [3:0] trig_bytes(input logic [1:0] lvl);
    logic [3:0] n;
    case (lvl)
      UART_FC_1:  n = 4'd1;
      UART_FC_4:  n = 4'd4;
      UART_FC_8:  n = 4'd8;
      default:    n = 4'd14;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_pop_seq.sv
// rtl/uart_rx_pop_seq.sv - one-pop-per-RBR-read sequencer and LSR read-release clear pulse
import uart_rx_int_ctrl_pkg::*;

module uart_rx_pop_seq (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic rbr_rd,
  input  logic lsr_rd,
  input  logic rf_nonempty,
  input  logic rx_clr,
  output logic rf_pop,
  output logic lsr_mask
);

  pop_state_e state, state_next;
  logic       rbr_rd_q;
  logic       lsr_rd_q;
  logic       rbr_rise;

  // A read access starts on the first cycle rbr_rd is high; a held strobe is one access
  assign rbr_rise = rbr_rd & ~rbr_rd_q;

  // Next-state: pop only on a fresh read of a non-empty FIFO; a FIFO reset wins
  always_comb begin
    state_next = state;
    if (rx_clr) begin
      state_next = PS_IDLE;
    end else begin
      case (state)
        PS_IDLE: if (rbr_rise && rf_nonempty) state_next = PS_POP;
        PS_POP:  state_next = PS_HOLD;
        PS_HOLD: if (!rbr_rd) state_next = PS_IDLE;
        default: state_next = PS_IDLE;
      endcase
    end
  end

  // State, strobe history and registered pulse outputs
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= PS_IDLE;
      rbr_rd_q <= 1'b0;
      lsr_rd_q <= 1'b0;
      rf_pop   <= 1'b0;
      lsr_mask <= 1'b0;
    end else begin
      state    <= state_next;
      rbr_rd_q <= rbr_rd;
      lsr_rd_q <= lsr_rd;
      rf_pop   <= (state_next == PS_POP);
      lsr_mask <= lsr_rd_q & ~lsr_rd;
    end
  end

endmodule

// File: rtl/uart_rx_int_ctrl.sv
// rtl/uart_rx_int_ctrl.sv - RX FIFO control pulses and prioritised receive interrupts (option: UART_RX_TIMEOUT_INT_EN)
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

import uart_rx_int_ctrl_pkg::*;

module uart_rx_int_ctrl #(
  parameter int FIFO_CNT_W = `UART_FIFO_COUNTER_W,
  parameter int TOC_W      = 10
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  rbr_rd,
  input  logic                  lsr_rd,
  input  logic                  fcr_wr,
  input  logic [7:0]            fcr_wdata,
  input  logic                  ier_rda,
  input  logic                  ier_rls,
  input  logic [FIFO_CNT_W-1:0] rf_count,
  input  logic                  rf_error_bit,
  input  logic                  rf_overrun,
  input  logic [TOC_W-1:0]      counter_t,
  output logic                  rf_pop,
  output logic                  rx_reset,
  output logic                  lsr_mask,
  output logic                  rda_int,
  output logic                  rls_int,
  output logic                  ti_int,
  output logic [3:0]            rx_iid,
  output logic                  rx_int_o
);

  logic                  rx_reset_req;
  logic [1:0]            trig_lvl;
  logic [FIFO_CNT_W-1:0] trig_cnt;
  logic                  rda_next;
  logic                  rls_next;
  logic                  ti_next;
  logic [3:0]            iid_next;
  logic                  unused_fcr_bits;

  assign rx_reset_req    = fcr_wr & fcr_wdata[1];
  assign trig_cnt        = FIFO_CNT_W'(trig_bytes(trig_lvl));
  assign unused_fcr_bits = ^{fcr_wdata[5:2], fcr_wdata[0]};

  uart_rx_pop_seq u_pop (
    .clk         (clk),
    .wb_rst_i    (wb_rst_i),
    .rbr_rd      (rbr_rd),
    .lsr_rd      (lsr_rd),
    .rf_nonempty (rf_count != '0),
    .rx_clr      (rx_reset_req | rx_reset),
    .rf_pop      (rf_pop),
    .lsr_mask    (lsr_mask)
  );

  // Next-state interrupt flags; line status set has priority over its clear
  always_comb begin
    rda_next = ier_rda && (rf_count >= trig_cnt);
    rls_next = rls_int;
    if (ier_rls && (rf_error_bit || rf_overrun)) rls_next = 1'b1;
    else if (lsr_mask)                           rls_next = 1'b0;
  end

`ifdef UART_RX_TIMEOUT_INT_EN
  // Timeout flag: any pop, FIFO reset or disable clears it before a new set is considered
  always_comb begin
    ti_next = ti_int;
    if (rf_pop || rx_reset || !ier_rda)          ti_next = 1'b0;
    else if (rf_count != '0 && counter_t == '0)  ti_next = 1'b1;
  end
`else
  logic unused_counter_t;
  assign unused_counter_t = ^counter_t;
  assign ti_next          = 1'b0;
`endif

  // IID from next-state flags so it lines up with the registered flags
  always_comb begin
    iid_next = UART_II_NONE;
    if (rls_next)      iid_next = UART_II_RLS;
    else if (rda_next) iid_next = UART_II_RDA;
    else if (ti_next)  iid_next = UART_II_TI;
  end

  // Registered FCR side effects and interrupt outputs
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_reset <= 1'b0;
      trig_lvl <= UART_FC_1;
      rda_int  <= 1'b0;
      rls_int  <= 1'b0;
      ti_int   <= 1'b0;
      rx_iid   <= UART_II_NONE;
      rx_int_o <= 1'b0;
    end else begin
      rx_reset <= rx_reset_req;
      if (fcr_wr) trig_lvl <= fcr_wdata[7:6];
      rda_int  <= rda_next;
      rls_int  <= rls_next;
      ti_int   <= ti_next;
      rx_iid   <= iid_next;
      rx_int_o <= rda_next | rls_next | ti_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_int_ctrl.sv
// tb/tb_uart_rx_int_ctrl.sv - directed self-checking bench for uart_rx_int_ctrl
module tb_uart_rx_int_ctrl;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       rbr_rd, lsr_rd, fcr_wr;
  logic [7:0] fcr_wdata;
  logic       ier_rda, ier_rls;
  logic [4:0] rf_count;
  logic       rf_error_bit, rf_overrun;
  logic [9:0] counter_t;
  logic       rf_pop, rx_reset, lsr_mask, rda_int, rls_int, ti_int, rx_int_o;
  logic [3:0] rx_iid;

  int total = 0;
  int bad   = 0;
  int pops;
  int first;
`ifdef UART_RX_TIMEOUT_INT_EN
  localparam logic       TI_ON  = 1'b1;
  localparam logic [3:0] TI_IID = 4'b1100;
`else
  localparam logic       TI_ON  = 1'b0;
  localparam logic [3:0] TI_IID = 4'b0001;
`endif

  uart_rx_int_ctrl u_dut (
    .clk          (clk),
    .wb_rst_i     (wb_rst_i),
    .rbr_rd       (rbr_rd),
    .lsr_rd       (lsr_rd),
    .fcr_wr       (fcr_wr),
    .fcr_wdata    (fcr_wdata),
    .ier_rda      (ier_rda),
    .ier_rls      (ier_rls),
    .rf_count     (rf_count),
    .rf_error_bit (rf_error_bit),
    .rf_overrun   (rf_overrun),
    .counter_t    (counter_t),
    .rf_pop       (rf_pop),
    .rx_reset     (rx_reset),
    .lsr_mask     (lsr_mask),
    .rda_int      (rda_int),
    .rls_int      (rls_int),
    .ti_int       (ti_int),
    .rx_iid       (rx_iid),
    .rx_int_o     (rx_int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wb_rst_i = 1'b1; rbr_rd = 1'b0; lsr_rd = 1'b0; fcr_wr = 1'b0; fcr_wdata = 8'h00;
    ier_rda = 1'b0; ier_rls = 1'b0; rf_count = 5'd0; rf_error_bit = 1'b0; rf_overrun = 1'b0;
    counter_t = 10'd100;
    repeat (2) @(posedge clk);
    #1 wb_rst_i = 1'b0;

    check("rst_rf_pop",   rf_pop,   1'b0);
    check("rst_rx_reset", rx_reset, 1'b0);
    check("rst_lsr_mask", lsr_mask, 1'b0);
    check("rst_rda",      rda_int,  1'b0);
    check("rst_rls",      rls_int,  1'b0);
    check("rst_ti",       ti_int,   1'b0);
    check("rst_iid",      rx_iid,   4'b0001);
    check("rst_int",      rx_int_o, 1'b0);
    step();

    // held read of a 3-byte FIFO: one pop, visible right after the first read edge
    rf_count = 5'd3; pops = 0; first = -1;
    for (int c = 0; c < 6; c++) begin
      rbr_rd = (c < 4);
      step();
      if (rf_pop) begin
        pops++;
        if (first < 0) first = c;
        rf_count = rf_count - 5'd1;
      end
    end
    rbr_rd = 1'b0;
    check("held_read_pops", pops, 1);
    check("pop_latency", first, 0);

    // read on empty FIFO, FIFO fills while the strobe is still held: no pop
    rf_count = 5'd0; pops = 0;
    rbr_rd = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rf_count = 5'd1;
      step();
      if (rf_pop) pops++;
    end
    rbr_rd = 1'b0; rf_count = 5'd0;
    step();
    check("empty_read_pops", pops, 0);

    // trigger level 14
    fcr_wr = 1'b1; fcr_wdata = 8'hC0;
    step();
    fcr_wr = 1'b0;
    check("fcr_c0_no_reset", rx_reset, 1'b0);
    ier_rda = 1'b1; rf_count = 5'd13;
    step();
    check("rda_13", rda_int, 1'b0);
    check("iid_13", rx_iid, 4'b0001);
    rf_count = 5'd14;
    step();
    check("rda_14", rda_int, 1'b1);
    check("iid_14", rx_iid, 4'b0100);
    check("int_14", rx_int_o, 1'b1);

    // overrun over RDA, then LSR read clears it after the read completes
    ier_rls = 1'b1; rf_overrun = 1'b1;
    step();
    check("rls_set", rls_int, 1'b1);
    check("iid_rls", rx_iid, 4'b0110);
    lsr_rd = 1'b1;
    step();
    check("mask_during_read", lsr_mask, 1'b0);
    lsr_rd = 1'b0; rf_overrun = 1'b0;
    step();
    check("mask_pulse", lsr_mask, 1'b1);
    check("rls_before_clear", rls_int, 1'b1);
    step();
    check("mask_one_cycle", lsr_mask, 1'b0);
    check("rls_cleared", rls_int, 1'b0);
    check("iid_back_rda", rx_iid, 4'b0100);

    // error still present across the clear: set wins
    rf_error_bit = 1'b1;
    step();
    lsr_rd = 1'b1; step();
    lsr_rd = 1'b0; step();
    step();
    check("rls_set_wins", rls_int, 1'b1);
    rf_error_bit = 1'b0;
    lsr_rd = 1'b1; step();
    lsr_rd = 1'b0; step();
    step();
    check("rls_clear2", rls_int, 1'b0);

    // character timeout below trigger level
    rf_count = 5'd1; counter_t = 10'd0;
    step();
    check("ti_set", ti_int, TI_ON);
    check("iid_ti", rx_iid, TI_IID);
    check("rda_below", rda_int, 1'b0);
    counter_t = 10'd5; rbr_rd = 1'b1;
    step();
    check("ti_read_pop", rf_pop, 1'b1);
    rbr_rd = 1'b0; rf_count = 5'd0;
    step();
    check("ti_cleared", ti_int, 1'b0);
    check("iid_none", rx_iid, 4'b0001);

    // RX reset together with a read: reset wins, no pop, timeout cleared
    rf_count = 5'd1; counter_t = 10'd0;
    step();
    rbr_rd = 1'b1; fcr_wr = 1'b1; fcr_wdata = 8'h02;
    step();
    check("rxrst_pulse", rx_reset, 1'b1);
    check("rxrst_no_pop", rf_pop, 1'b0);
    check("rxrst_ti_pre", ti_int, TI_ON);
    fcr_wr = 1'b0; fcr_wdata = 8'h00; rf_count = 5'd0; counter_t = 10'd100;
    step();
    check("rxrst_one_cycle", rx_reset, 1'b0);
    check("rxrst_no_pop2", rf_pop, 1'b0);
    check("rxrst_ti_clr", ti_int, 1'b0);
    check("rxrst_iid", rx_iid, 4'b0001);
    rbr_rd = 1'b0;
    step();

    // asynchronous reset in the middle of a pop
    rf_count = 5'd2; rbr_rd = 1'b1;
    step();
    check("pop_before_rst", rf_pop, 1'b1);
    #1 wb_rst_i = 1'b1;
    #1;
    check("pop_async_rst", rf_pop, 1'b0);
    check("iid_async_rst", rx_iid, 4'b0001);
    rbr_rd = 1'b0;
    #1 wb_rst_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
